// File: rtl/iir_biquad_mc_if.sv
// Sample, coefficient and result signals of the multi-channel biquad filter.
interface iir_biquad_mc_if #(
  parameter int DW  = 8,
  parameter int CW  = 16,
  parameter int NCH = 2
);
  localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1;

  logic           coef_we;
  logic [CHW-1:0] coef_ch;
  logic [2:0]     coef_sel;
  logic [CW-1:0]  coef_data;
  logic           state_clr;
  logic           in_valid;
  logic           in_ready;
  logic [CHW-1:0] in_ch;
  logic [DW-1:0]  in_data;
  logic           out_valid;
  logic [CHW-1:0] out_ch;
  logic [DW-1:0]  out_data;
  logic           sat;
  logic           err;

  modport master (
    output coef_we, coef_ch, coef_sel, coef_data, state_clr,
    output in_valid, in_ch, in_data,
    input  in_ready, out_valid, out_ch, out_data, sat, err
  );

  modport slave (
    input  coef_we, coef_ch, coef_sel, coef_data, state_clr,
    input  in_valid, in_ch, in_data,
    output in_ready, out_valid, out_ch, out_data, sat, err
  );
endinterface

// File: rtl/iir_biquad_mc.sv
// Time-multiplexed multi-channel Direct Form I biquad with one shared
// multiplier, round-half-up and output saturation.
module iir_biquad_mc #(
  parameter int DW  = 8,
  parameter int CW  = 16,
  parameter int NCH = 2
) (
  input logic            clk,
  input logic            reset,
  iir_biquad_mc_if.slave bus
);
  localparam int CHW  = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int FRAC = CW - 2;
  localparam int PW   = DW + CW;
  localparam int AW   = DW + CW + 4;
  localparam logic signed [AW-1:0] ROUND_C = {{(AW-FRAC){1'b0}}, 1'b1, {(FRAC-1){1'b0}}};
  localparam logic signed [AW-1:0] MAX_C   = {{(AW-DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [AW-1:0] MIN_C   = {{(AW-DW+1){1'b1}}, {(DW-1){1'b0}}};
  localparam logic [2:0]           LAST_K  = 3'd4;

  typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;

  state_t                state_q, state_d;
  logic [2:0]            k_q;
  logic [CHW-1:0]        ch_q;
  logic signed [DW-1:0]  x_q;
  logic signed [AW-1:0]  acc_q;
  logic signed [CW-1:0]  coef_q [NCH][5];
  logic signed [DW-1:0]  x1_q [NCH];
  logic signed [DW-1:0]  x2_q [NCH];
  logic signed [DW-1:0]  y1_q [NCH];
  logic signed [DW-1:0]  y2_q [NCH];
  logic                  out_valid_q, sat_q, err_q;
  logic [CHW-1:0]        out_ch_q;
  logic [DW-1:0]         out_data_q;

  logic                  inReady, accept, chOk, coefWr, coefDrop, clrEn, macEn, outEn;
  logic signed [DW-1:0]  sampleOp;
  logic signed [CW-1:0]  coefOp;
  logic                  subOp;
  logic signed [PW-1:0]  product;
  logic signed [AW-1:0]  prodExt, accNext, shifted;
  logic                  satHi, satLo;
  logic [DW-1:0]         yRes;

  // FSM state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // FSM next state: a good-channel acceptance starts five MAC steps, then one output step
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept && chOk) state_d = MAC;
      MAC:     if (k_q == LAST_K) state_d = OUT;
      OUT:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs and qualified strobes; writes and clears are only honoured while idle
  always_comb begin
    inReady  = (state_q == IDLE) && !bus.state_clr;
    accept   = bus.in_valid && inReady;
    chOk     = int'(bus.in_ch) < NCH;
    coefWr   = bus.coef_we && (state_q == IDLE) && (bus.coef_sel <= 3'd4) &&
               (int'(bus.coef_ch) < NCH);
    coefDrop = bus.coef_we && !coefWr;
    clrEn    = (state_q == IDLE) && bus.state_clr;
    macEn    = (state_q == MAC);
    outEn    = (state_q == OUT);
  end

  // Multiplier operand select: feed-forward terms add, feedback terms subtract
  always_comb begin
    sampleOp = '0;
    coefOp   = '0;
    subOp    = 1'b0;
    case (k_q)
      3'd0: begin sampleOp = x_q;         coefOp = coef_q[ch_q][0]; end
      3'd1: begin sampleOp = x1_q[ch_q];  coefOp = coef_q[ch_q][1]; end
      3'd2: begin sampleOp = x2_q[ch_q];  coefOp = coef_q[ch_q][2]; end
      3'd3: begin sampleOp = y1_q[ch_q];  coefOp = coef_q[ch_q][3]; subOp = 1'b1; end
      3'd4: begin sampleOp = y2_q[ch_q];  coefOp = coef_q[ch_q][4]; subOp = 1'b1; end
      default: ;
    endcase
  end

  assign product = sampleOp * coefOp;
  assign prodExt = {{(AW-PW){product[PW-1]}}, product};
  assign accNext = subOp ? (acc_q - prodExt) : (acc_q + prodExt);
  assign shifted = acc_q >>> FRAC;
  assign satHi   = shifted > MAX_C;
  assign satLo   = shifted < MIN_C;
  assign yRes    = satHi ? {1'b0, {(DW-1){1'b1}}} :
                   satLo ? {1'b1, {(DW-1){1'b0}}} : shifted[DW-1:0];

  // Sample latch and accumulator; preset to half an LSB so the final shift rounds half up
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      k_q   <= '0;
      ch_q  <= '0;
      x_q   <= '0;
      acc_q <= '0;
    end else if (accept && chOk) begin
      k_q   <= '0;
      ch_q  <= bus.in_ch;
      x_q   <= bus.in_data;
      acc_q <= ROUND_C;
    end else if (macEn) begin
      k_q   <= k_q + 3'd1;
      acc_q <= accNext;
    end
  end

  // Coefficient banks, written only from idle so a running sample never sees a change
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int c = 0; c < NCH; c++)
        for (int s = 0; s < 5; s++)
          coef_q[c][s] <= '0;
    end else if (coefWr) begin
      coef_q[bus.coef_ch][bus.coef_sel] <= bus.coef_data;
    end
  end

  // History banks: global clear from idle, otherwise shift the finished channel
  always_ff @(posedge clk or posedge reset) begin
    if (reset || clrEn) begin
      for (int c = 0; c < NCH; c++) begin
        x1_q[c] <= '0;
        x2_q[c] <= '0;
        y1_q[c] <= '0;
        y2_q[c] <= '0;
      end
    end else if (outEn) begin
      x2_q[ch_q] <= x1_q[ch_q];
      x1_q[ch_q] <= x_q;
      y2_q[ch_q] <= y1_q[ch_q];
      y1_q[ch_q] <= yRes;
    end
  end

  // Registered result, saturation flag and error pulse; out_data holds between results
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      out_ch_q    <= '0;
      out_data_q  <= '0;
      sat_q       <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      out_valid_q <= outEn;
      sat_q       <= outEn && (satHi || satLo);
      err_q       <= coefDrop || (accept && !chOk);
      if (outEn) begin
        out_ch_q   <= ch_q;
        out_data_q <= yRes;
      end
    end
  end

  assign bus.in_ready  = inReady;
  assign bus.out_valid = out_valid_q;
  assign bus.out_ch    = out_ch_q;
  assign bus.out_data  = out_data_q;
  assign bus.sat       = sat_q;
  assign bus.err       = err_q;
endmodule

// File: tb/tb_iir_biquad_mc.sv
// Self-checking bench for iir_biquad_mc against an arithmetic biquad model.
module tb_iir_biquad_mc;
  localparam int DW  = 8;
  localparam int CW  = 16;
  localparam int NCH = 3;
  localparam int CHW = 2;

  logic clk = 1'b0;
  logic reset;
  int   nVec = 0;
  int   nMis = 0;

  int cB  [NCH][5];
  int hX1 [NCH];
  int hX2 [NCH];
  int hY1 [NCH];
  int hY2 [NCH];

  iir_biquad_mc_if #(.DW(DW), .CW(CW), .NCH(NCH)) bus ();

  iir_biquad_mc #(.DW(DW), .CW(CW), .NCH(NCH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Global time limit in case the design stops responding entirely
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout, want finish");
    $fatal(1, "[TB] watchdog");
  end

  function automatic void modelReset();
    for (int c = 0; c < NCH; c++) begin
      for (int s = 0; s < 5; s++) cB[c][s] = 0;
      hX1[c] = 0; hX2[c] = 0; hY1[c] = 0; hY2[c] = 0;
    end
  endfunction

  function automatic void modelClear();
    for (int c = 0; c < NCH; c++) begin
      hX1[c] = 0; hX2[c] = 0; hY1[c] = 0; hY2[c] = 0;
    end
  endfunction

  function automatic void modelWrite(input int ch, input int sel, input int data);
    logic signed [15:0] t;
    t = data[15:0];
    if (sel <= 4 && ch < NCH) cB[ch][sel] = int'(t);
  endfunction

  // y = clip(floor((sum + 2^13) / 2^14)), then shift the channel history
  function automatic void modelStep(input int ch, input int x, output int y, output logic s);
    longint acc, q;
    acc = 64'sd8192
        + longint'(cB[ch][0]) * longint'(x)
        + longint'(cB[ch][1]) * longint'(hX1[ch])
        + longint'(cB[ch][2]) * longint'(hX2[ch])
        - longint'(cB[ch][3]) * longint'(hY1[ch])
        - longint'(cB[ch][4]) * longint'(hY2[ch]);
    q = acc >>> 14;
    s = 1'b0;
    if (q > 127)       begin q = 127;  s = 1'b1; end
    else if (q < -128) begin q = -128; s = 1'b1; end
    y = int'(q);
    hX2[ch] = hX1[ch]; hX1[ch] = x;
    hY2[ch] = hY1[ch]; hY1[ch] = y;
  endfunction

  task automatic writeCoef(input int ch, input int sel, input int data, output logic errSeen);
    @(negedge clk);
    bus.coef_we   = 1'b1;
    bus.coef_ch   = ch[CHW-1:0];
    bus.coef_sel  = sel[2:0];
    bus.coef_data = data[CW-1:0];
    @(posedge clk); #1;
    errSeen = bus.err;
    bus.coef_we = 1'b0;
    modelWrite(ch, sel, data);
  endtask

  task automatic clearState(output logic readySeen);
    @(negedge clk);
    bus.state_clr = 1'b1;
    #1 readySeen = bus.in_ready;
    @(posedge clk); #1;
    bus.state_clr = 1'b0;
    modelClear();
  endtask

  // Offers one sample, optionally with a coefficient write at edge T+wrEdge, and observes the result
  task automatic applyStimulus(input int ch, input int x, input int wrEdge, input int wrCh,
                               input int wrSel, input int wrData,
                               output logic gotValid, output int gotData, output logic gotSat,
                               output int gotCh, output int lat, output int readyLow,
                               output logic errAcc, output logic errWr, output logic pulseOk);
    int guard;
    gotValid = 1'b0; gotData = 0; gotSat = 1'b0; gotCh = -1; lat = -1;
    errWr = 1'b0; pulseOk = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_ch    = ch[CHW-1:0];
    bus.in_data  = x[DW-1:0];
    if (wrEdge == 0) begin
      bus.coef_we = 1'b1; bus.coef_ch = wrCh[CHW-1:0];
      bus.coef_sel = wrSel[2:0]; bus.coef_data = wrData[CW-1:0];
    end
    guard = 0;
    while (!bus.in_ready && guard < 20) begin @(negedge clk); guard++; end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    errAcc = bus.err;
    if (wrEdge == 0) begin errWr = bus.err; bus.coef_we = 1'b0; end
    readyLow = bus.in_ready ? 0 : 1;
    for (int e = 1; e <= 20 && !gotValid; e++) begin
      if (wrEdge == e) begin
        bus.coef_we = 1'b1; bus.coef_ch = wrCh[CHW-1:0];
        bus.coef_sel = wrSel[2:0]; bus.coef_data = wrData[CW-1:0];
      end
      @(posedge clk); #1;
      if (wrEdge == e) begin errWr = bus.err; bus.coef_we = 1'b0; end
      if (bus.out_valid) begin
        gotValid = 1'b1; lat = e;
        gotData = int'($signed(bus.out_data));
        gotSat = bus.sat; gotCh = int'(bus.out_ch);
      end else if (!bus.in_ready) begin
        readyLow++;
      end
    end
    if (gotValid) begin
      @(posedge clk); #1;
      pulseOk = !bus.out_valid && (int'($signed(bus.out_data)) == gotData);
    end
  endtask

  task automatic test_reset();
    nVec++; if (bus.in_ready !== 1'b1) begin nMis++; $display("[TB] FAIL reset_in_ready: got %b, want 1", bus.in_ready); end
    nVec++; if (bus.out_valid !== 1'b0) begin nMis++; $display("[TB] FAIL reset_out_valid: got %b, want 0", bus.out_valid); end
    nVec++; if (bus.out_ch !== 2'd0) begin nMis++; $display("[TB] FAIL reset_out_ch: got %0d, want 0", bus.out_ch); end
    nVec++; if (bus.out_data !== 8'd0) begin nMis++; $display("[TB] FAIL reset_out_data: got %0d, want 0", bus.out_data); end
    nVec++; if (bus.sat !== 1'b0) begin nMis++; $display("[TB] FAIL reset_sat: got %b, want 0", bus.sat); end
    nVec++; if (bus.err !== 1'b0) begin nMis++; $display("[TB] FAIL reset_err: got %b, want 0", bus.err); end
  endtask

  task automatic test_zero_coef();
    logic v, s, ea, ew, po; int d, c, l, rl, ey; logic es;
    applyStimulus(0, 55, -1, 0, 0, 0, v, d, s, c, l, rl, ea, ew, po);
    modelStep(0, 55, ey, es);
    nVec++; if (!v || d !== ey) begin nMis++; $display("[TB] FAIL zero_data: got %0d (valid %b), want %0d", d, v, ey); end
    nVec++; if (s !== es) begin nMis++; $display("[TB] FAIL zero_sat: got %b, want %b", s, es); end
    nVec++; if (l !== 6) begin nMis++; $display("[TB] FAIL zero_latency: got %0d, want 6", l); end
  endtask

  task automatic test_passthrough();
    logic v, s, ea, ew, po, es, e; int d, c, l, rl, ey;
    int xs [3] = '{37, -128, 127};
    writeCoef(0, 0, 16'h4000, e);
    nVec++; if (e !== 1'b0) begin nMis++; $display("[TB] FAIL pass_wr_err: got %b, want 0", e); end
    foreach (xs[i]) begin
      applyStimulus(0, xs[i], -1, 0, 0, 0, v, d, s, c, l, rl, ea, ew, po);
      modelStep(0, xs[i], ey, es);
      nVec++; if (!v || d !== ey) begin nMis++; $display("[TB] FAIL pass_data: got %0d (valid %b), want %0d", d, v, ey); end
      nVec++; if (l !== 6) begin nMis++; $display("[TB] FAIL pass_latency: got %0d, want 6", l); end
      nVec++; if (rl !== 6) begin nMis++; $display("[TB] FAIL pass_ready_low: got %0d, want 6", rl); end
      nVec++; if (!po) begin nMis++; $display("[TB] FAIL pass_pulse_hold: got 0, want 1"); end
      nVec++; if (c !== 0 || s !== es) begin nMis++; $display("[TB] FAIL pass_ch_sat: got ch %0d sat %b, want 0 %b", c, s, es); end
    end
  endtask

  task automatic test_round_sat();
    logic v, s, ea, ew, po, es, e; int d, c, l, rl, ey;
    int xs [4] = '{3, -3, 100, -100};
    for (int i = 0; i < 4; i++) begin
      if (i == 0) writeCoef(0, 0, 16'h2000, e);
      if (i == 2) writeCoef(0, 0, 16'h7FFF, e);
      applyStimulus(0, xs[i], -1, 0, 0, 0, v, d, s, c, l, rl, ea, ew, po);
      modelStep(0, xs[i], ey, es);
      nVec++; if (!v || d !== ey) begin nMis++; $display("[TB] FAIL round_data: got %0d, want %0d", d, ey); end
      nVec++; if (s !== es) begin nMis++; $display("[TB] FAIL round_sat: got %b, want %b", s, es); end
    end
  endtask

  task automatic test_recursion();
    logic v, s, ea, ew, po, es, e, r; int d, c, l, rl, ey;
    int chs [8] = '{1, 0, 1, 0, 1, 0, 1, 0};
    int xs  [8] = '{64, 20, 0, -5, 0, 90, 0, -77};
    writeCoef(0, 0, 16'h4000, e);
    writeCoef(1, 0, 16'h4000, e);
    writeCoef(1, 3, 16'hE000, e);
    for (int i = 0; i < 8; i++) begin
      applyStimulus(chs[i], xs[i], -1, 0, 0, 0, v, d, s, c, l, rl, ea, ew, po);
      modelStep(chs[i], xs[i], ey, es);
      nVec++; if (!v || d !== ey) begin nMis++; $display("[TB] FAIL recur_data: got %0d, want %0d", d, ey); end
      nVec++; if (c !== chs[i]) begin nMis++; $display("[TB] FAIL recur_ch: got %0d, want %0d", c, chs[i]); end
    end
    clearState(r);
    nVec++; if (r !== 1'b0) begin nMis++; $display("[TB] FAIL clr_ready: got %b, want 0", r); end
    applyStimulus(1, 0, -1, 0, 0, 0, v, d, s, c, l, rl, ea, ew, po);
    modelStep(1, 0, ey, es);
    nVec++; if (!v || d !== ey) begin nMis++; $display("[TB] FAIL clr_data: got %0d, want %0d", d, ey); end
  endtask

  task automatic test_errors();
    logic v, s, ea, ew, po, es, e; int d, c, l, rl, ey;
    writeCoef(0, 0, 16'h4000, e);
    applyStimulus(0, 50, 3, 0, 0, 16'h0000, v, d, s, c, l, rl, ea, ew, po);
    modelStep(0, 50, ey, es);
    nVec++; if (ew !== 1'b1) begin nMis++; $display("[TB] FAIL busy_wr_err: got %b, want 1", ew); end
    nVec++; if (!v || d !== ey) begin nMis++; $display("[TB] FAIL busy_wr_data: got %0d, want %0d", d, ey); end
    writeCoef(0, 6, 16'h1234, e);
    nVec++; if (e !== 1'b1) begin nMis++; $display("[TB] FAIL bad_sel_err: got %b, want 1", e); end
    writeCoef(NCH, 0, 16'h1234, e);
    nVec++; if (e !== 1'b1) begin nMis++; $display("[TB] FAIL bad_wr_ch_err: got %b, want 1", e); end
    applyStimulus(NCH, 11, -1, 0, 0, 0, v, d, s, c, l, rl, ea, ew, po);
    nVec++; if (ea !== 1'b1) begin nMis++; $display("[TB] FAIL bad_ch_err: got %b, want 1", ea); end
    nVec++; if (v !== 1'b0) begin nMis++; $display("[TB] FAIL bad_ch_valid: got %b, want 0", v); end
    applyStimulus(0, 40, 0, 0, 0, 16'h2000, v, d, s, c, l, rl, ea, ew, po);
    modelWrite(0, 0, 16'h2000);
    modelStep(0, 40, ey, es);
    nVec++; if (!v || d !== ey) begin nMis++; $display("[TB] FAIL same_edge_wr_data: got %0d, want %0d", d, ey); end
    nVec++; if (ea !== 1'b0) begin nMis++; $display("[TB] FAIL same_edge_wr_err: got %b, want 0", ea); end
  endtask

  task automatic test_async_reset();
    logic v, s, ea, ew, po, es, e; int d, c, l, rl, ey, seen;
    writeCoef(1, 0, 16'h4000, e);
    seen = 0;
    @(negedge clk);
    bus.in_valid = 1'b1; bus.in_ch = 2'd1; bus.in_data = 8'd64;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(posedge clk);
    reset = 1'b1;
    #1;
    nVec++; if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin nMis++; $display("[TB] FAIL arst_outputs: got ready %b valid %b, want 1 0", bus.in_ready, bus.out_valid); end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (bus.out_valid) seen++;
    end
    nVec++; if (seen !== 0) begin nMis++; $display("[TB] FAIL arst_no_valid: got %0d pulses, want 0", seen); end
    modelReset();
    applyStimulus(1, 64, -1, 0, 0, 0, v, d, s, c, l, rl, ea, ew, po);
    modelStep(1, 64, ey, es);
    nVec++; if (!v || d !== ey) begin nMis++; $display("[TB] FAIL arst_impulse: got %0d, want %0d", d, ey); end
  endtask

  task automatic test_random();
    logic v, s, ea, ew, po, es, e; int d, c, l, rl, ey, ch, x, val;
    for (int cc = 0; cc < NCH; cc++)
      for (int sl = 0; sl < 5; sl++) begin
        val = (sl < 3) ? int'($urandom_range(0, 32767)) - 16384 : int'($urandom_range(0, 16383)) - 8192;
        writeCoef(cc, sl, val, e);
      end
    for (int i = 0; i < 40; i++) begin
      if (i % 8 == 7) begin
        val = int'($urandom_range(0, 65535)) - 32768;
        writeCoef(int'($urandom_range(0, NCH - 1)), int'($urandom_range(0, 2)), val, e);
      end
      ch = int'($urandom_range(0, NCH - 1));
      x  = int'($urandom_range(0, 255)) - 128;
      applyStimulus(ch, x, -1, 0, 0, 0, v, d, s, c, l, rl, ea, ew, po);
      modelStep(ch, x, ey, es);
      nVec++; if (!v || d !== ey) begin nMis++; $display("[TB] FAIL rand_data: ch %0d x %0d got %0d, want %0d", ch, x, d, ey); end
      nVec++; if (s !== es) begin nMis++; $display("[TB] FAIL rand_sat: got %b, want %b", s, es); end
    end
  endtask

  // Reset, then run every scenario in sequence and print the tally
  initial begin
    reset = 1'b1;
    bus.coef_we = 1'b0; bus.coef_ch = '0; bus.coef_sel = '0; bus.coef_data = '0;
    bus.state_clr = 1'b0; bus.in_valid = 1'b0; bus.in_ch = '0; bus.in_data = '0;
    modelReset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    test_reset();
    test_zero_coef();
    test_passthrough();
    test_round_sat();
    test_recursion();
    test_errors();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
    $finish;
  end
endmodule
